// File: rtl/led_line_shifter.sv
// HUB75 line shifter: fetches one row of upper/lower pixels from the framebuffer
// and serialises one PWM bit-plane onto the panel RGB lines with a shift clock.
module led_line_shifter #(
    parameter int COLS     = 64,
    parameter int COL_BITS = 6,
    parameter int ROW_BITS = 5,
    parameter int PIX_BITS = 12
) (
    input  logic                         clk_25MHz,
    input  logic                         rst_n,
    input  logic                         next_line_begin,
    input  logic [ROW_BITS-1:0]          next_line_addr,
    input  logic [3:0]                   next_line_pwm,
    output logic                         next_line_done,
    output logic                         busy,
    output logic                         ram_rd,
    output logic [ROW_BITS+COL_BITS:0]   ram_addr,
    input  logic [PIX_BITS-1:0]          ram_data,
    output logic                         r0,
    output logic                         g0,
    output logic                         b0,
    output logic                         r1,
    output logic                         g1,
    output logic                         b1,
    output logic                         sclk,
    output logic [2:0]                   dbg_state
);

    // Line handshake: a one-cycle next_line_begin is accepted only in IDLE or
    // DONE (row/plane sampled on that edge); next_line_done pulses for one
    // cycle once the last column has been clocked. Requests while busy are dropped.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_A_TOP  = 3'd1,
        S_A_BOT  = 3'd2,
        S_CAPT   = 3'd3,
        S_CLK_HI = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);
    localparam logic [COL_BITS-1:0] COL_ONE  = COL_BITS'(1);

    state_t                state_q, state_d;
    logic [COL_BITS-1:0]   col_q, col_d;
    logic [ROW_BITS-1:0]   row_q, row_d;
    logic [1:0]            plane_q, plane_d;
    logic [2:0]            stage_q, stage_d;
    logic [5:0]            rgb_q, rgb_d;
    logic [5:0]            rgb_out;

    logic unused_pwm_hi;
    assign unused_pwm_hi = ^next_line_pwm[3:2];

    // Selects {R,G,B} bits of the requested bit-plane from a 4:4:4 pixel.
    function automatic logic [2:0] pick(input logic [PIX_BITS-1:0] pix,
                                        input logic [1:0] pl);
        pick = {pix[{2'b10, pl}], pix[{2'b01, pl}], pix[{2'b00, pl}]};
    endfunction

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            plane_q <= '0;
            stage_q <= '0;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            stage_q <= stage_d;
            rgb_q   <= rgb_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        plane_d        = plane_q;
        stage_d        = stage_q;
        rgb_d          = rgb_q;
        rgb_out        = rgb_q;
        next_line_done = 1'b0;
        busy           = 1'b0;
        ram_rd         = 1'b0;
        ram_addr       = '0;
        sclk           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (next_line_begin) begin
                    state_d = S_A_TOP;
                    col_d   = '0;
                    row_d   = next_line_addr;
                    plane_d = next_line_pwm[1:0];
                end
            end
            S_A_TOP: begin
                busy     = 1'b1;
                ram_rd   = 1'b1;
                ram_addr = {1'b0, row_q, col_q};
                state_d  = S_A_BOT;
            end
            S_A_BOT: begin
                busy     = 1'b1;
                ram_rd   = 1'b1;
                ram_addr = {1'b1, row_q, col_q};
                // Top pixel read in A_TOP arrives now.
                stage_d  = pick(ram_data, plane_q);
                state_d  = S_CAPT;
            end
            S_CAPT: begin
                busy    = 1'b1;
                // Bottom pixel arrives this cycle; present it now as setup.
                rgb_out = {stage_q, pick(ram_data, plane_q)};
                rgb_d   = rgb_out;
                state_d = S_CLK_HI;
            end
            S_CLK_HI: begin
                busy = 1'b1;
                sclk = 1'b1;
                if (col_q == COL_LAST) begin
                    state_d = S_DONE;
                end else begin
                    col_d   = col_q + COL_ONE;
                    state_d = S_A_TOP;
                end
            end
            S_DONE: begin
                next_line_done = 1'b1;
                if (next_line_begin) begin
                    state_d = S_A_TOP;
                    col_d   = '0;
                    row_d   = next_line_addr;
                    plane_d = next_line_pwm[1:0];
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign {r0, g0, b0, r1, g1, b1} = rgb_out;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_led_line_shifter.sv
// Self-checking bench for led_line_shifter: table vectors, random lines against
// a framebuffer-level model, plus reset/re-pulse/back-to-back sequences.
module tb_led_line_shifter;

    localparam int COLS     = 4;
    localparam int COL_BITS = 6;
    localparam int ROW_BITS = 5;
    localparam int PIX_BITS = 12;
    localparam int AW       = 1 + ROW_BITS + COL_BITS;
    localparam int LINE_CYC = 4 * COLS + 1;

    logic                 clk_25MHz = 1'b0;
    logic                 rst_n;
    logic                 next_line_begin;
    logic [ROW_BITS-1:0]  next_line_addr;
    logic [3:0]           next_line_pwm;
    logic                 next_line_done;
    logic                 busy;
    logic                 ram_rd;
    logic [AW-1:0]        ram_addr;
    logic [PIX_BITS-1:0]  ram_data;
    logic                 r0, g0, b0, r1, g1, b1;
    logic                 sclk;
    logic [2:0]           dbg_state;

    led_line_shifter #(
        .COLS(COLS), .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .PIX_BITS(PIX_BITS)
    ) dut (
        .clk_25MHz(clk_25MHz), .rst_n(rst_n),
        .next_line_begin(next_line_begin), .next_line_addr(next_line_addr),
        .next_line_pwm(next_line_pwm), .next_line_done(next_line_done),
        .busy(busy), .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_data(ram_data),
        .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
        .sclk(sclk), .dbg_state(dbg_state)
    );

    // ---------------- clock / framebuffer ----------------
    always #20 clk_25MHz = ~clk_25MHz;

    logic [PIX_BITS-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk_25MHz) if (ram_rd) ram_data <= mem[ram_addr];

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int          got_addr[$];
    logic [5:0]  got_rgb[$];
    int          done_n[$];
    int          busy_cnt;
    int          first_rd_n;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    function automatic int pix_addr(input int half, input int row, input int col);
        return half * (1 << (ROW_BITS + COL_BITS)) + row * (1 << COL_BITS) + col;
    endfunction

    function automatic logic [5:0] model_rgb(input int row, input int pwm, input int col);
        int p, t, b;
        p = pwm % 4;
        t = int'(mem[pix_addr(0, row, col)]);
        b = int'(mem[pix_addr(1, row, col)]);
        return 6'(((t >> (8 + p)) & 1) * 32 + ((t >> (4 + p)) & 1) * 16 + ((t >> p) & 1) * 8 +
                  ((b >> (8 + p)) & 1) * 4 + ((b >> (4 + p)) & 1) * 2 + ((b >> p) & 1));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_line(input int row, input int pwm);
        @(negedge clk_25MHz);
        next_line_begin = 1'b1;
        next_line_addr  = ROW_BITS'(row);
        next_line_pwm   = 4'(pwm);
    endtask

    // Observes one line starting at the edge that accepted begin; optionally
    // re-pulses begin mid-line or chains a new request in the done cycle.
    task automatic run_line(input int row, input int pwm, input bit chain,
                            input int chain_row, input int chain_pwm,
                            input int repulse_at, input int repulse_row);
        logic last_sclk;
        int   n_end;
        got_addr.delete(); got_rgb.delete(); done_n.delete();
        busy_cnt = 0; first_rd_n = -1; last_sclk = 1'b0;
        n_end = chain ? LINE_CYC : LINE_CYC + 3;
        for (int n = 1; n <= n_end; n++) begin
            @(negedge clk_25MHz);
            if (ram_rd) begin
                got_addr.push_back(int'(ram_addr));
                if (first_rd_n < 0) first_rd_n = n;
            end
            if (sclk && !last_sclk) got_rgb.push_back({r0, g0, b0, r1, g1, b1});
            last_sclk = sclk;
            if (next_line_done) done_n.push_back(n);
            if (busy) busy_cnt++;
            next_line_begin = 1'b0;
            if (n == repulse_at) begin
                next_line_begin = 1'b1;
                next_line_addr  = ROW_BITS'(repulse_row);
                next_line_pwm   = 4'($urandom_range(0, 15));
            end
            if (chain && n == LINE_CYC) begin
                next_line_begin = 1'b1;
                next_line_addr  = ROW_BITS'(chain_row);
                next_line_pwm   = 4'(chain_pwm);
            end
        end
        chk("addr_count", got_addr.size(), 2 * COLS);
        for (int i = 0; i < got_addr.size() && i < 2 * COLS; i++)
            chk($sformatf("addr[%0d]", i), got_addr[i], pix_addr(i % 2, row, i / 2));
        chk("sclk_edges", got_rgb.size(), COLS);
        for (int c = 0; c < got_rgb.size() && c < COLS; c++)
            chk($sformatf("rgb_col%0d", c), got_rgb[c], model_rgb(row, pwm, c));
        chk("done_count", done_n.size(), 1);
        chk("done_cycle", (done_n.size() > 0) ? done_n[0] : -1, LINE_CYC);
        chk("busy_cycles", busy_cnt, 4 * COLS);
        chk("first_rd_cycle", first_rd_n, 1);
        if (!chain)
            chk("rgb_hold", {r0, g0, b0, r1, g1, b1}, model_rgb(row, pwm, COLS - 1));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          row;
        int          pwm;
        logic [11:0] top;
        logic [11:0] bot;
        logic [2:0]  exp_top;
        logic [2:0]  exp_bot;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{5,  0, 12'h124, 12'h421, 3'b100, 3'b001};
        vecs[1] = '{5,  1, 12'h124, 12'h421, 3'b010, 3'b010};
        vecs[2] = '{10, 2, 12'hA5C, 12'h3F0, 3'b011, 3'b010};
        vecs[3] = '{31, 3, 12'h888, 12'h888, 3'b111, 3'b111};
        vecs[4] = '{0,  7, 12'h888, 12'h777, 3'b111, 3'b000};
        vecs[5] = '{17, 12, 12'hFFF, 12'h000, 3'b111, 3'b000};

        for (int a = 0; a < (1 << AW); a++) mem[a] = PIX_BITS'($urandom);
        rst_n = 1'b0; next_line_begin = 1'b0; next_line_addr = '0; next_line_pwm = '0;
        #5;
        chk("reset_outputs", {next_line_done, busy, ram_rd, ram_addr, r0, g0, b0, r1, g1, b1, sclk}, 0);
        repeat (2) @(negedge clk_25MHz);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_25MHz);
        chk("idle_after_reset", {next_line_done, busy, ram_rd, sclk}, 0);

        // Table-driven lines: every column carries the same pixel pair.
        for (int v = 0; v < 6; v++) begin
            for (int c = 0; c < COLS; c++) begin
                mem[pix_addr(0, vecs[v].row, c)] = vecs[v].top;
                mem[pix_addr(1, vecs[v].row, c)] = vecs[v].bot;
            end
            start_line(vecs[v].row, vecs[v].pwm);
            run_line(vecs[v].row, vecs[v].pwm, 1'b0, 0, 0, -1, 0);
            for (int c = 0; c < got_rgb.size(); c++)
                chk($sformatf("vec%0d_col%0d", v, c), got_rgb[c], {vecs[v].exp_top, vecs[v].exp_bot});
        end

        // Random lines against the model.
        for (int t = 0; t < 8; t++) begin
            int row, pwm;
            row = $urandom_range(0, 31);
            pwm = $urandom_range(0, 15);
            for (int c = 0; c < COLS; c++) begin
                mem[pix_addr(0, row, c)] = PIX_BITS'($urandom);
                mem[pix_addr(1, row, c)] = PIX_BITS'($urandom);
            end
            start_line(row, pwm);
            run_line(row, pwm, 1'b0, 0, 0, -1, 0);
        end

        // Reset mid-line after two shift clocks.
        begin
            int rises;
            logic last;
            for (int c = 0; c < COLS; c++) begin
                mem[pix_addr(0, 3, c)] = 12'hFFF;
                mem[pix_addr(1, 3, c)] = 12'hFFF;
            end
            start_line(3, 1);
            rises = 0; last = 1'b0;
            for (int n = 0; n < 40 && rises < 2; n++) begin
                @(negedge clk_25MHz);
                next_line_begin = 1'b0;
                if (sclk && !last) rises++;
                last = sclk;
            end
            chk("pre_reset_sclk_edges", rises, 2);
            chk("pre_reset_rgb", {r0, g0, b0, r1, g1, b1}, 6'h3F);
            #5 rst_n = 1'b0;
            #1;
            chk("midline_reset_outputs",
                {next_line_done, busy, ram_rd, ram_addr, r0, g0, b0, r1, g1, b1, sclk}, 0);
            @(negedge clk_25MHz);
            rst_n = 1'b1;
            begin
                int dcnt;
                dcnt = 0;
                for (int n = 0; n < 20; n++) begin
                    @(negedge clk_25MHz);
                    if (next_line_done || busy) dcnt++;
                end
                chk("no_done_after_abort", dcnt, 0);
            end
            start_line(3, 1);
            run_line(3, 1, 1'b0, 0, 0, -1, 0);
        end

        // Begin re-pulsed mid-line with another row is ignored.
        start_line(2, 2);
        run_line(2, 2, 1'b0, 0, 0, 7, 9);

        // Begin in the DONE cycle chains a line with no idle gap.
        start_line(1, 0);
        run_line(1, 0, 1'b1, 6, 2, -1, 0);
        run_line(6, 2, 1'b0, 0, 0, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
